// File: rtl/seg_count_gen_pkg.sv
// Shared definitions for the seven-segment stimulus counter: mode encodings,
// BCD nibble width and a constant power-of-ten helper for the binary view.
package seg_count_gen_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  // Elaboration-time constant; only ever called with loop-constant arguments.
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/seg_count_gen_if.sv
// Control and count bus of seg_count_gen; master drives controls, slave
// (the counter) drives the count views and event pulses.
interface seg_count_gen_if #(
  parameter int DIGITS = 6,
  parameter int DATA_W = 20
);
  logic                  en;
  logic [1:0]            mode;
  logic                  load;
  logic [4*DIGITS-1:0]   load_bcd;
  logic [4*DIGITS-1:0]   bcd;
  logic [DATA_W-1:0]     data;
  logic                  tick;
  logic                  wrap;
  logic                  dir;

  modport master (
    output en, mode, load, load_bcd,
    input  bcd, data, tick, wrap, dir
  );

  modport slave (
    input  en, mode, load, load_bcd,
    output bcd, data, tick, wrap, dir
  );
endinterface

// File: rtl/seg_count_gen_bcd_digit.sv
// One decimal digit of the counter: increments/decrements when its carry-in is
// set at a step, loads with clamp to 9, and reports carry/borrow to the next digit.
module bcd_digit
  import seg_count_gen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             cin_i,
  input  logic             load_i,
  input  logic [NIB_W-1:0] load_val_i,
  output logic [NIB_W-1:0] q_o,
  output logic             cout_o
);

  logic [NIB_W-1:0] q_q, q_d;

  // Carry/borrow is independent of step so the top digit's out doubles as
  // the all-nines / all-zeros detector for wrap.
  assign cout_o = cin_i & ((inc_i & (q_q == 4'd9)) | (dec_i & (q_q == 4'd0)));

  always_comb begin
    q_d = q_q;
    if (load_i)
      q_d = (load_val_i > 4'd9) ? 4'd9 : load_val_i;
    else if (step_i && cin_i && inc_i)
      q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
    else if (step_i && cin_i && dec_i)
      q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/seg_count_gen.sv
// Decimal stimulus counter for the seven-segment path: prescaled BCD count with
// up/down/ping-pong/hold modes, pause, parallel load and a registered binary view.
module seg_count_gen
  import seg_count_gen_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int TICK_CYCLES = 5_000_000,
  parameter int DATA_W      = 20
) (
  input  logic           clk,
  input  logic           rst,
  seg_count_gen_if.slave bus
);

  localparam int BW = NIB_W * DIGITS;
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic              boundary, step;
  logic [BW-1:0]     bcd;
  logic              is_max, is_zero, msd_cout;
  logic              inc, dec, wrap_c, dir_d;
  logic              dir_q, tick_q, wrap_q;
  logic [DATA_W-1:0] data_d, data_q;
  mode_e             mode;

  assign mode     = mode_e'(bus.mode);
  assign boundary = bus.en && (pcnt_q == PLAST);
  assign step     = boundary && !bus.load;
  assign is_max   = (bcd == {DIGITS{4'd9}});
  assign is_zero  = (bcd == '0);

  always_comb begin
    pcnt_d = pcnt_q;
    if (bus.load)    pcnt_d = '0;
    else if (bus.en) pcnt_d = boundary ? '0 : pcnt_q + 1'b1;
  end

  // Direction request to the digits; ping-pong turnarounds reverse the
  // request on the extreme value so MAX steps to MAX-1 and 0 steps to 1.
  always_comb begin
    inc    = 1'b0;
    dec    = 1'b0;
    wrap_c = 1'b0;
    dir_d  = dir_q;
    case (mode)
      MODE_UP: begin
        inc    = 1'b1;
        wrap_c = msd_cout;
        dir_d  = 1'b0;
      end
      MODE_DOWN: begin
        dec    = 1'b1;
        wrap_c = msd_cout;
        dir_d  = 1'b1;
      end
      MODE_PINGPONG: begin
        if (!dir_q) begin
          if (is_max) begin
            dec    = 1'b1;
            dir_d  = 1'b1;
            wrap_c = 1'b1;
          end else begin
            inc = 1'b1;
          end
        end else begin
          if (is_zero) begin
            inc    = 1'b1;
            dir_d  = 1'b0;
            wrap_c = 1'b1;
          end else begin
            dec = 1'b1;
          end
        end
      end
      default: dir_d = 1'b0;
    endcase
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic cin, cout;
    if (i == 0) begin : g_lsd
      assign cin = 1'b1;
    end else begin : g_rip
      assign cin = g_dig[i-1].cout;
    end
    bcd_digit u_dig (
      .clk        (clk),
      .rst        (rst),
      .step_i     (step),
      .inc_i      (inc),
      .dec_i      (dec),
      .cin_i      (cin),
      .load_i     (bus.load),
      .load_val_i (bus.load_bcd[i*NIB_W +: NIB_W]),
      .q_o        (bcd[i*NIB_W +: NIB_W]),
      .cout_o     (cout)
    );
  end

  assign msd_cout = g_dig[DIGITS-1].cout;

  always_comb begin
    data_d = '0;
    for (int i = 0; i < DIGITS; i++)
      data_d = data_d + DATA_W'(bcd[i*NIB_W +: NIB_W]) * DATA_W'(pow10(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      dir_q  <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      data_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      data_q <= data_d;
      tick_q <= step;
      wrap_q <= step & wrap_c;
      if (step) dir_q <= dir_d;
    end
  end

  assign bus.bcd  = bcd;
  assign bus.data = data_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;
  assign bus.dir  = dir_q;

endmodule

// File: tb/tb_seg_count_gen.sv
// Scoreboard bench for seg_count_gen (DIGITS=2, TICK_CYCLES=4): an integer model
// predicts every post-edge state, a monitor pops and compares each cycle.
module tb_seg_count_gen;

  localparam int D    = 2;
  localparam int T    = 4;
  localparam int DW   = 8;
  localparam int MAXV = 99;

  typedef struct {
    int cnt;
    int data;
    bit tick;
    bit wrap;
    bit dir;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_count_gen_if #(.DIGITS(D), .DATA_W(DW)) bus ();

  seg_count_gen #(.DIGITS(D), .TICK_CYCLES(T), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   m_cnt, m_pcnt, m_data;
  bit   m_dir;
  int   n_chk, n_pass;

  function automatic int clamp_val(input logic [7:0] v);
    int lo, hi;
    lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
    hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input int md, output bit w);
    w = 1'b0;
    case (md)
      0: begin
        m_dir = 1'b0;
        w     = (m_cnt == MAXV);
        m_cnt = (m_cnt + 1) % (MAXV + 1);
      end
      1: begin
        m_dir = 1'b1;
        w     = (m_cnt == 0);
        m_cnt = (m_cnt + MAXV) % (MAXV + 1);
      end
      2: begin
        if (!m_dir) begin
          if (m_cnt == MAXV) begin m_dir = 1'b1; m_cnt = MAXV - 1; w = 1'b1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_dir = 1'b0; m_cnt = 1; w = 1'b1; end
          else m_cnt = m_cnt - 1;
        end
      end
      default: m_dir = 1'b0;
    endcase
  endtask

  // Applies one cycle of inputs and queues the state expected after the edge.
  task automatic drive(input bit r, input bit e, input int md, input bit ld,
                       input logic [7:0] lv);
    exp_t x;
    bit   w;
    @(negedge clk);
    rst          = r;
    bus.en       = e;
    bus.mode     = md[1:0];
    bus.load     = ld;
    bus.load_bcd = lv;
    x.tick = 1'b0;
    x.wrap = 1'b0;
    if (r) begin
      m_cnt = 0; m_pcnt = 0; m_dir = 1'b0; m_data = 0;
    end else begin
      m_data = m_cnt;
      if (ld) begin
        m_cnt  = clamp_val(lv);
        m_pcnt = 0;
      end else if (e) begin
        if (m_pcnt == T - 1) begin
          m_pcnt = 0;
          x.tick = 1'b1;
          model_step(md, w);
          x.wrap = w;
        end else begin
          m_pcnt = m_pcnt + 1;
        end
      end
    end
    x.cnt  = m_cnt;
    x.data = m_data;
    x.dir  = m_dir;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        n_chk++;
        if (bus.bcd === to_bcd(x.cnt) && bus.data === DW'(x.data) &&
            bus.tick === x.tick && bus.wrap === x.wrap && bus.dir === x.dir)
          n_pass++;
        else
          $display("FAIL state chk%0d: got bcd=%h data=%0d tick=%b wrap=%b dir=%b, want bcd=%h data=%0d tick=%b wrap=%b dir=%b",
                   n_chk, bus.bcd, bus.data, bus.tick, bus.wrap, bus.dir,
                   to_bcd(x.cnt), x.data, x.tick, x.wrap, x.dir);
      end
    end
  end

  initial begin : stim
    int md;
    bit seen;
    int k;
    bus.en = 1'b0; bus.mode = 2'b00; bus.load = 1'b0; bus.load_bcd = '0;
    n_chk = 0; n_pass = 0;

    // up-wrap through a full 99 -> 00 rollover
    repeat (3) drive(1, 0, 0, 0, 8'h00);
    @(posedge clk);
    #2;
    n_chk++;
    if (bus.bcd === 8'h00 && bus.data === '0 && bus.tick === 1'b0 &&
        bus.wrap === 1'b0 && bus.dir === 1'b0)
      n_pass++;
    else
      $display("FAIL reset state: bcd=%h data=%0d tick=%b wrap=%b dir=%b",
               bus.bcd, bus.data, bus.tick, bus.wrap, bus.dir);
    repeat (4 * 100 + 8) drive(0, 1, 0, 0, 8'h00);

    // down-wrap from reset
    repeat (2) drive(1, 0, 1, 0, 8'h00);
    repeat (12) drive(0, 1, 1, 0, 8'h00);

    // ping-pong turnarounds at both ends
    drive(1, 0, 2, 0, 8'h00);
    drive(0, 1, 2, 1, 8'h97);
    repeat (16) drive(0, 1, 2, 0, 8'h00);
    drive(0, 1, 2, 1, 8'h01);
    repeat (12) drive(0, 1, 2, 0, 8'h00);

    // load with clamp, coincident with a step boundary
    drive(0, 1, 0, 0, 8'h00);
    while (m_pcnt != T - 1) drive(0, 1, 0, 0, 8'h00);
    drive(0, 1, 0, 1, 8'h3F);
    repeat (8) drive(0, 1, 0, 0, 8'h00);

    // pause mid-period, then hold mode
    repeat (2) drive(0, 1, 0, 0, 8'h00);
    repeat (10) drive(0, 0, 0, 0, 8'h00);
    repeat (10) drive(0, 1, 0, 0, 8'h00);
    repeat (12) drive(0, 1, 3, 0, 8'h00);

    // reset overrides a coincident load
    drive(0, 1, 0, 1, 8'h57);
    repeat (2) drive(0, 1, 0, 0, 8'h00);
    drive(1, 1, 0, 1, 8'h12);
    seen = 1'b0;
    for (k = 0; k < 2 * T && !seen; k++) begin
      drive(0, 1, 0, 0, 8'h00);
      @(posedge clk);
      #2;
      seen = (bus.tick === 1'b1);
    end
    n_chk++;
    if (seen) n_pass++;
    else $display("FAIL wait expired: no tick within %0d cycles after reset", 2 * T);
    repeat (8) drive(0, 1, 0, 0, 8'h00);

    // randomized mix
    md = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) md = int'($urandom_range(0, 3));
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, md,
            $urandom_range(0, 29) == 0, 8'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
